// File: rtl/intc.sv
// ---------------------------------------------------------------------------
// intc - eight-source interrupt controller for the single-cycle CPU.
//
// Captures peripheral requests into `pending`, gates them with a software
// mask and tracks in-service levels in `active`. The control unit sees
// one-hot `min_bit_s` (highest-priority enabled pending request) and
// `min_bit_a` (highest-priority in-service level). Lower bit index means
// higher priority, so `min_bit_s < min_bit_a` means preemption.
//
// Build option:
//   INTC_EDGE_EN  defined   -> edge-triggered capture, overrun tracking
//                 undefined -> level-sensitive capture, overrun tied to 0
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   irq            peripheral request lines (bits [RSVD-1:0] ignored)
//   we_mask        mask write strobe, mask_in = new enable mask
//   clr_ovr        clear overrun and err (a simultaneous new set wins)
//   s_calli        one-hot level entered this cycle (from control unit)
//   s_reti         one-hot level exited this cycle (from control unit)
//   min_bit_s      lowest set bit of pending & mask, else 0
//   min_bit_a      lowest set bit of active, else 0
//   pending        pending register
//   active         in-service register
//   overrun        sticky: request arrived while already pending
//   err            sticky protocol error
// ---------------------------------------------------------------------------
module intc #(
    parameter int N_IRQ = 8,
    parameter int RSVD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             we_mask,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             clr_ovr,
    input  logic [N_IRQ-1:0] s_calli,
    input  logic [N_IRQ-1:0] s_reti,
    output logic [N_IRQ-1:0] min_bit_s,
    output logic [N_IRQ-1:0] min_bit_a,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] active,
    output logic [N_IRQ-1:0] overrun,
    output logic             err
);

    // Trap levels never pend from irq and cannot be unmasked.
    localparam logic [N_IRQ-1:0] PERIPH_M = {{(N_IRQ-RSVD){1'b1}}, {RSVD{1'b0}}};
    localparam logic [N_IRQ-1:0] ONE      = {{(N_IRQ-1){1'b0}}, 1'b1};

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] active_q,  active_d;
    logic [N_IRQ-1:0] mask_q,    mask_d;
    logic             err_q,     err_d;
    logic             err_set;

    // ---------------------------------------------------------------------
    // Protocol checking on the control-unit strobes
    // ---------------------------------------------------------------------
    logic calli_multi, reti_multi;

    always_comb begin
        // x & (x-1) is non-zero exactly when more than one bit is set
        calli_multi = |(s_calli & (s_calli - ONE));
        reti_multi  = |(s_reti  & (s_reti  - ONE));
        err_set     = (|(s_calli & active_q)) | (|(s_reti & ~active_q))
                    | calli_multi | reti_multi;
    end

    // ---------------------------------------------------------------------
    // Next-state logic shared by both capture modes
    // ---------------------------------------------------------------------
    always_comb begin
        // Clear from reti first, then set from calli: same bit in both ends set.
        active_d = (active_q & ~s_reti) | s_calli;
        mask_d   = we_mask ? (mask_in & PERIPH_M) : mask_q;
        err_d    = (clr_ovr ? 1'b0 : err_q) | err_set;
    end

`ifdef INTC_EDGE_EN
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] overrun_q, overrun_d;
    logic [N_IRQ-1:0] evt;

    always_comb begin
        evt       = irq & ~irq_q & PERIPH_M;
        // A new event beats the call clear, so a request is never lost.
        pending_d = evt | (pending_q & ~s_calli);
        overrun_d = (clr_ovr ? '0 : overrun_q) | (evt & pending_q & ~s_calli);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            overrun_q <= '0;
        end else begin
            irq_q     <= irq;
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    // Level mode: pending simply mirrors the (unreserved) request lines.
    always_comb begin
        pending_d = irq & PERIPH_M;
    end

    assign overrun = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            active_q  <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
        end
    end

    // Priority encoders read registers only: no path from the strobes or irq.
    logic [N_IRQ-1:0] req_en;

    always_comb begin
        req_en    = pending_q & mask_q;
        min_bit_s = req_en   & (~req_en   + ONE);
        min_bit_a = active_q & (~active_q + ONE);
    end

    assign pending = pending_q;
    assign active  = active_q;
    assign err     = err_q;

endmodule

// File: tb/tb_intc.sv
module tb_intc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq = '0;
    logic       we_mask = 1'b0;
    logic [7:0] mask_in = '0;
    logic       clr_ovr = 1'b0;
    logic [7:0] s_calli = '0;
    logic [7:0] s_reti = '0;
    logic [7:0] min_bit_s, min_bit_a, pending, active, overrun;
    logic       err;

    int vecs = 0;
    int miss = 0;

    intc dut (
        .clk(clk), .reset(reset), .irq(irq), .we_mask(we_mask), .mask_in(mask_in),
        .clr_ovr(clr_ovr), .s_calli(s_calli), .s_reti(s_reti),
        .min_bit_s(min_bit_s), .min_bit_a(min_bit_a), .pending(pending),
        .active(active), .overrun(overrun), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        irq = '0; we_mask = 1'b0; mask_in = '0; clr_ovr = 1'b0; s_calli = '0; s_reti = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_in();
        irq = 8'hFF; s_calli = 8'h10;
        step(); step();
        reset = 1'b0; clear_in();
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL rst_pending got %h exp %h", pending, 8'h00); end
        vecs++; if (active !== 8'h00) begin miss++; $display("FAIL rst_active got %h exp %h", active, 8'h00); end
        vecs++; if (min_bit_s !== 8'h00) begin miss++; $display("FAIL rst_min_s got %h exp %h", min_bit_s, 8'h00); end
        vecs++; if (min_bit_a !== 8'h00) begin miss++; $display("FAIL rst_min_a got %h exp %h", min_bit_a, 8'h00); end
        vecs++; if (overrun !== 8'h00) begin miss++; $display("FAIL rst_overrun got %h exp %h", overrun, 8'h00); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL rst_err got %b exp %b", err, 1'b0); end
    endtask

    task automatic test_call_nest();
        we_mask = 1'b1; mask_in = 8'hFC; step(); clear_in();
        irq = 8'h10; step();
        vecs++; if (pending !== 8'h10) begin miss++; $display("FAIL req_pending got %h exp %h", pending, 8'h10); end
        vecs++; if (min_bit_s !== 8'h10) begin miss++; $display("FAIL req_min_s got %h exp %h", min_bit_s, 8'h10); end
        irq = 8'h00; s_calli = 8'h10; step(); clear_in();
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL call_pending got %h exp %h", pending, 8'h00); end
        vecs++; if (active !== 8'h10) begin miss++; $display("FAIL call_active got %h exp %h", active, 8'h10); end
        vecs++; if (min_bit_a !== 8'h10) begin miss++; $display("FAIL call_min_a got %h exp %h", min_bit_a, 8'h10); end
        vecs++; if (min_bit_s !== 8'h00) begin miss++; $display("FAIL call_min_s got %h exp %h", min_bit_s, 8'h00); end
        // Higher-priority source preempts
        irq = 8'h04; step();
        vecs++; if (min_bit_s !== 8'h04) begin miss++; $display("FAIL nest_min_s got %h exp %h", min_bit_s, 8'h04); end
        irq = 8'h00; s_calli = 8'h04; step(); clear_in();
        vecs++; if (active !== 8'h14) begin miss++; $display("FAIL nest_active got %h exp %h", active, 8'h14); end
        vecs++; if (min_bit_a !== 8'h04) begin miss++; $display("FAIL nest_min_a got %h exp %h", min_bit_a, 8'h04); end
        s_reti = 8'h04; step(); clear_in();
        vecs++; if (min_bit_a !== 8'h10) begin miss++; $display("FAIL ret_min_a got %h exp %h", min_bit_a, 8'h10); end
        s_reti = 8'h10; step(); clear_in();
        vecs++; if (min_bit_a !== 8'h00) begin miss++; $display("FAIL ret2_min_a got %h exp %h", min_bit_a, 8'h00); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL nest_err got %b exp %b", err, 1'b0); end
        // Reserved trap bits never pend from irq
        irq = 8'h03; step(); clear_in();
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL rsvd_pending got %h exp %h", pending, 8'h00); end
    endtask

    task automatic test_mask();
        we_mask = 1'b1; mask_in = 8'h00; irq = 8'h20; step();
        we_mask = 1'b0;
        vecs++; if (pending !== 8'h20) begin miss++; $display("FAIL mask_pending got %h exp %h", pending, 8'h20); end
        vecs++; if (min_bit_s !== 8'h00) begin miss++; $display("FAIL mask_min_s got %h exp %h", min_bit_s, 8'h00); end
        we_mask = 1'b1; mask_in = 8'h20; step();
        we_mask = 1'b0;
        vecs++; if (min_bit_s !== 8'h20) begin miss++; $display("FAIL unmask_min_s got %h exp %h", min_bit_s, 8'h20); end
        vecs++; if (overrun !== 8'h00) begin miss++; $display("FAIL hold_overrun got %h exp %h", overrun, 8'h00); end
        irq = 8'h00; s_calli = 8'h20; step(); clear_in();
        s_reti = 8'h20; step(); clear_in();
        vecs++; if (active !== 8'h00) begin miss++; $display("FAIL mask_active got %h exp %h", active, 8'h00); end
        we_mask = 1'b1; mask_in = 8'hFF; step(); clear_in();
    endtask

    task automatic test_overrun();
        irq = 8'h08; step(); irq = 8'h00; step(); irq = 8'h08; step();
`ifdef INTC_EDGE_EN
        vecs++; if (overrun !== 8'h08) begin miss++; $display("FAIL ovr_set got %h exp %h", overrun, 8'h08); end
        irq = 8'h00; clr_ovr = 1'b1; step(); clear_in();
        vecs++; if (overrun !== 8'h00) begin miss++; $display("FAIL ovr_clr got %h exp %h", overrun, 8'h00); end
        // New request in the same cycle as the call is kept, no overrun
        irq = 8'h08; s_calli = 8'h08; step(); clear_in();
        vecs++; if (pending !== 8'h08) begin miss++; $display("FAIL ovr_call_pend got %h exp %h", pending, 8'h08); end
        vecs++; if (overrun !== 8'h00) begin miss++; $display("FAIL ovr_call_ovr got %h exp %h", overrun, 8'h00); end
        s_reti = 8'h08; step(); clear_in();
        s_calli = 8'h08; step(); clear_in();
        s_reti = 8'h08; step(); clear_in();
`else
        vecs++; if (overrun !== 8'h00) begin miss++; $display("FAIL ovr_level got %h exp %h", overrun, 8'h00); end
        clear_in(); step();
`endif
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL ovr_end_pend got %h exp %h", pending, 8'h00); end
        vecs++; if (active !== 8'h00) begin miss++; $display("FAIL ovr_end_active got %h exp %h", active, 8'h00); end
    endtask

    task automatic test_trap_err();
        irq = 8'h40; step();
        s_calli = 8'h01; step(); s_calli = 8'h00;
        vecs++; if (active !== 8'h01) begin miss++; $display("FAIL trap_active got %h exp %h", active, 8'h01); end
        vecs++; if (pending !== 8'h40) begin miss++; $display("FAIL trap_pending got %h exp %h", pending, 8'h40); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL trap_err0 got %b exp %b", err, 1'b0); end
        vecs++; if (min_bit_s !== 8'h40) begin miss++; $display("FAIL trap_min_s got %h exp %h", min_bit_s, 8'h40); end
        s_calli = 8'h01; step(); s_calli = 8'h00;
        vecs++; if (err !== 1'b1) begin miss++; $display("FAIL reentry_err got %b exp %b", err, 1'b1); end
        s_reti = 8'h02; step(); s_reti = 8'h00;
        vecs++; if (err !== 1'b1) begin miss++; $display("FAIL badret_err got %b exp %b", err, 1'b1); end
        vecs++; if (active !== 8'h01) begin miss++; $display("FAIL badret_active got %h exp %h", active, 8'h01); end
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL err_clr got %b exp %b", err, 1'b0); end
        // Multi-bit strobe flags an error but still updates active
        s_calli = 8'h0C; step(); s_calli = 8'h00;
        vecs++; if (err !== 1'b1) begin miss++; $display("FAIL multi_err got %b exp %b", err, 1'b1); end
        vecs++; if (active !== 8'h0D) begin miss++; $display("FAIL multi_active got %h exp %h", active, 8'h0D); end
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        // Clear with a simultaneous new error: set wins
        clr_ovr = 1'b1; s_reti = 8'h80; step(); clr_ovr = 1'b0; s_reti = 8'h00;
        vecs++; if (err !== 1'b1) begin miss++; $display("FAIL clr_vs_set got %b exp %b", err, 1'b1); end
        // Same bit in reti and calli ends set
        s_reti = 8'h04; s_calli = 8'h04; step(); s_reti = 8'h00; s_calli = 8'h00;
        vecs++; if (active !== 8'h0D) begin miss++; $display("FAIL reti_calli got %h exp %h", active, 8'h0D); end
    endtask

    task automatic test_reset_mid();
        // active=0D, pending=40 at this point
        irq = 8'h00; reset = 1'b1; step(); reset = 1'b0;
        vecs++; if (active !== 8'h00) begin miss++; $display("FAIL mid_active got %h exp %h", active, 8'h00); end
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL mid_pending got %h exp %h", pending, 8'h00); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL mid_err got %b exp %b", err, 1'b0); end
        vecs++; if (min_bit_a !== 8'h00) begin miss++; $display("FAIL mid_min_a got %h exp %h", min_bit_a, 8'h00); end
    endtask

    task automatic test_level_hold();
        we_mask = 1'b1; mask_in = 8'hFC; irq = 8'h40; step(); we_mask = 1'b0;
        s_calli = 8'h40; step(); s_calli = 8'h00;
        vecs++; if (active !== 8'h40) begin miss++; $display("FAIL hold_active got %h exp %h", active, 8'h40); end
`ifdef INTC_EDGE_EN
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL hold_pending got %h exp %h", pending, 8'h00); end
`else
        vecs++; if (pending !== 8'h40) begin miss++; $display("FAIL hold_pending got %h exp %h", pending, 8'h40); end
        step();
        vecs++; if (min_bit_s !== 8'h40) begin miss++; $display("FAIL hold_min_s got %h exp %h", min_bit_s, 8'h40); end
`endif
        irq = 8'h00; step();
        vecs++; if (pending !== 8'h00) begin miss++; $display("FAIL drop_pending got %h exp %h", pending, 8'h00); end
    endtask

    initial begin
        test_reset();
        test_call_nest();
        test_mask();
        test_overrun();
        test_trap_err();
        test_reset_mid();
        test_level_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/intc.md
# intc

Eight-source interrupt controller for the single-cycle CPU. It captures peripheral requests, applies a software mask, and tracks which levels are in service. It presents the control unit with one-hot `min_bit_s` (highest-priority pending request) and `min_bit_a` (highest-priority in-service level). It updates its state from the control unit's `s_calli` (interrupt taken) and `s_reti` (interrupt returned) strobes. Priority rule: lower bit index means higher priority, so one-hot numeric compare `min_bit_s < min_bit_a` means preemption.

## Interface
- `N_IRQ`, 8: number of sources. The block is verified only at 8; `s_calli`/`s_reti` widths follow it.
- `RSVD`, 2: low sources reserved for CPU-internal traps (bit 0 ALU overflow, bit 1 stack overflow). They never pend from `irq`.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `irq` in 8: peripheral request lines, synchronous to `clk`; bits [RSVD-1:0] ignored.
- `we_mask` in 1: write strobe for mask register.
- `mask_in` in 8: new enable mask; 1 = enabled.
- `clr_ovr` in 1: clear all overrun and error flags.
- `s_calli` in 8: one-hot (or 0) from the control unit; the level being entered this cycle.
- `s_reti` in 8: one-hot (or 0) from the control unit; the level being exited this cycle.
- `min_bit_s` out 8: one-hot lowest set bit of `pending & mask`, else 0.
- `min_bit_a` out 8: one-hot lowest set bit of `active`, else 0.
- `pending` out 8: pending register.
- `active` out 8: in-service register.
- `overrun` out 8: sticky; a request arrived while already pending.
- `err` out 1: sticky protocol error.

## Operation
- Registers: `pending`, `active`, `mask`, `overrun`, `err`, and `irq_q` (previous `irq` sample, used for edge detection).
- Request event on source i (i ≥ RSVD): `irq[i] & ~irq_q[i]` in edge mode; `irq[i]` in level mode (see Configuration).
- `pending[i]` next value, in priority order:
  - event → 1
  - else `s_calli[i]` → 0
  - else hold
- A new event in the same cycle as `s_calli[i]` leaves `pending[i]` = 1; the new request is not lost.
- Event while `pending[i]` already 1 and no `s_calli[i]` this cycle → `overrun[i]` set.
- Masked sources still pend; the mask gates only `min_bit_s`. Unmasking a pending source therefore raises `min_bit_s` immediately.
- `active` next value = `(active & ~s_reti) | s_calli`.
  - The reti clear is applied before the calli set, so the same bit in both strobes ends set.
  - Trap levels (bits 0–1) enter `active` through `s_calli` only.
- `err` is set when any of the following occurs:
  - `s_calli` has a bit already in `active` (re-entry)
  - `s_reti` has a bit not in `active`
  - `s_calli` or `s_reti` has more than one bit set
- On an `err` condition, the register update still proceeds as defined above.
- `mask` loads `mask_in` on `we_mask`; bits [RSVD-1:0] read as 0.
- `clr_ovr` clears `overrun` and `err`. A simultaneous new set wins.
- `min_bit_s` and `min_bit_a` are combinational from registers only, with no path from `s_calli`/`s_reti`/`irq`. This avoids loops through the combinational control unit.

## Timing
- Reset: `pending`, `active`, `mask`, `overrun`, `irq_q` = 0; `err` = 0. Therefore `min_bit_s` = `min_bit_a` = 0.
- Reset mid-service discards all active and pending state.
- Request latency: `irq` rising sampled at edge k → `pending` set after edge k; `min_bit_s` valid in cycle k+1.
- Call handshake: the control unit asserts `s_calli` for exactly one cycle, in the same cycle it observes `min_bit_s`. At the next edge the pending bit clears and the active bit sets, so `min_bit_s` drops (or advances to the next source) and `min_bit_a` updates in the following cycle.
- Return: `s_reti` one cycle → active bit clears at the next edge; `min_bit_a` falls to the next-lowest active bit, or 0.
- Nesting depth is bounded only by the 8 active bits.
- A held `irq` level generates no further events in edge mode.

## Configuration
- `INTC_EDGE_EN` defined: edge-triggered capture via `irq_q` as above; `overrun` is meaningful.
- `INTC_EDGE_EN` undefined: level-sensitive.
  - `pending[i]` = `irq[i]` registered each cycle; `s_calli` has no effect on `pending`.
  - `overrun` is tied to 0.
  - `irq_q` is removed.

## Test plan
- Reset, then mask=8'hFC, pulse `irq`=8'h10 for one cycle → cycle after: `pending`=8'h10, `min_bit_s`=8'h10; `s_calli`=8'h10 one cycle → `pending`=0, `active`=8'h10, `min_bit_a`=8'h10.
- Same state, pulse `irq[2]` → `min_bit_s`=8'h04 (less than 8'h10); `s_calli`=8'h04 → `active`=8'h14, `min_bit_a`=8'h04; `s_reti`=8'h04 → `min_bit_a`=8'h10.
- mask=0, pulse `irq[5]` → `pending`=8'h20, `min_bit_s`=0; write mask=8'h20 → `min_bit_s`=8'h20 in the next cycle.
- Two `irq[3]` pulses without a call → `overrun`=8'h08; `clr_ovr` → 0; new pulse in the same cycle as `s_calli`=8'h08 → `pending[3]` stays 1, no overrun.
- `s_calli`=8'h01 (ALU trap) → `active`=8'h01, `pending` unchanged; second `s_calli`=8'h01 → `err`=1; `s_reti`=8'h02 with bit 1 inactive → `err` stays 1.
- Assert `reset` with `active`=8'h14 and `pending`=8'h40 → all outputs 0 after the edge. Without `INTC_EDGE_EN`: hold `irq[6]` high → `pending[6]` stays 1 through `s_calli`.
